// File: rtl/rng_health_monitor_if.sv
// Sample/result bundle between the dual-LFSR generator side and the health monitor.
interface rng_health_monitor_if #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned WINDOW = 1024
);
   localparam int unsigned CW = $clog2(WINDOW * WIDTH + 1);

   logic             en;
   logic             clear;
   logic [WIDTH-1:0] rnd1;
   logic [WIDTH-1:0] rnd2;
   logic [CW-1:0]    ones_total;
   logic             window_done;
   logic             stuck_alarm;
   logic             corr_alarm;
   logic             bias_alarm;
   logic             alarm;

   modport master (
      output en, clear, rnd1, rnd2,
      input  ones_total, window_done, stuck_alarm, corr_alarm, bias_alarm, alarm
   );

   modport slave (
      input  en, clear, rnd1, rnd2,
      output ones_total, window_done, stuck_alarm, corr_alarm, bias_alarm, alarm
   );
endinterface

// File: rtl/rng_health_monitor.sv
// Online health tests on two random streams: repetition, cross-stream equality and
// per-window ones bias, each raising a sticky alarm.
module rng_health_monitor #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned WINDOW    = 1024,
   parameter int unsigned REP_LIMIT = 4,
   parameter int unsigned BIAS_TOL  = 512
) (
   input  logic                 clk,
   input  logic                 reset,
   rng_health_monitor_if.slave  bus
);
   localparam int unsigned CW  = $clog2(WINDOW * WIDTH + 1);
   localparam int unsigned CW1 = CW + 1;
   localparam int unsigned WW  = $clog2(WINDOW);
   localparam int unsigned RW  = $clog2(REP_LIMIT);
   localparam int unsigned EW  = $clog2(REP_LIMIT + 1);
   localparam int unsigned PW  = $clog2(WIDTH + 1);

   localparam logic [CW:0]   HALF    = CW1'(WINDOW * WIDTH / 2);
   localparam logic [CW:0]   TOL     = CW1'(BIAS_TOL);
   localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT - 1);
   localparam logic [EW-1:0] EQ_MAX  = EW'(REP_LIMIT);
   localparam logic [WW-1:0] WIN_END = WW'(WINDOW - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

   state_e           state_q,       state_d;
   logic [WIDTH-1:0] prev1_q,       prev1_d;
   logic [WIDTH-1:0] prev2_q,       prev2_d;
   logic [RW-1:0]    rep1_q,        rep1_d;
   logic [RW-1:0]    rep2_q,        rep2_d;
   logic [EW-1:0]    eq_cnt_q,      eq_cnt_d;
   logic [CW-1:0]    acc_q,         acc_d;
   logic [WW-1:0]    win_cnt_q,     win_cnt_d;
   logic [CW-1:0]    ones_total_q,  ones_total_d;
   logic             window_done_q, window_done_d;
   logic             stuck_q,       stuck_d;
   logic             corr_q,        corr_d;
   logic             bias_q,        bias_d;
   logic             alarm_q,       alarm_d;

   logic [PW-1:0]    pop;
   logic [CW-1:0]    sum;
   logic [CW:0]      dev;

   function automatic logic [PW-1:0] popcnt(input logic [WIDTH-1:0] v);
      logic [PW-1:0] n;
      n = '0;
      for (int i = 0; i < int'(WIDTH); i++) n = n + PW'(v[i]);
      return n;
   endfunction

   // Next-state: clear has priority over an accepted sample.
   always_comb begin
      state_d       = state_q;
      prev1_d       = prev1_q;
      prev2_d       = prev2_q;
      rep1_d        = rep1_q;
      rep2_d        = rep2_q;
      eq_cnt_d      = eq_cnt_q;
      acc_d         = acc_q;
      win_cnt_d     = win_cnt_q;
      ones_total_d  = ones_total_q;
      window_done_d = 1'b0;
      stuck_d       = stuck_q;
      corr_d        = corr_q;
      bias_d        = bias_q;

      pop = popcnt(bus.rnd1);
      sum = acc_q + CW'(pop);
      dev = ({1'b0, sum} >= HALF) ? ({1'b0, sum} - HALF) : (HALF - {1'b0, sum});

      if (bus.clear) begin
         state_d      = IDLE;
         prev1_d      = '0;
         prev2_d      = '0;
         rep1_d       = '0;
         rep2_d       = '0;
         eq_cnt_d     = '0;
         acc_d        = '0;
         win_cnt_d    = '0;
         ones_total_d = '0;
         stuck_d      = 1'b0;
         corr_d       = 1'b0;
         bias_d       = 1'b0;
      end else if (bus.en) begin
         state_d = RUN;
         prev1_d = bus.rnd1;
         prev2_d = bus.rnd2;

         // First sample after IDLE is only a reference for repetition.
         if (state_q == RUN && bus.rnd1 == prev1_q)
            rep1_d = (rep1_q == REP_MAX) ? rep1_q : rep1_q + RW'(1);
         else
            rep1_d = '0;
         if (state_q == RUN && bus.rnd2 == prev2_q)
            rep2_d = (rep2_q == REP_MAX) ? rep2_q : rep2_q + RW'(1);
         else
            rep2_d = '0;

         if (bus.rnd1 == bus.rnd2)
            eq_cnt_d = (eq_cnt_q == EQ_MAX) ? eq_cnt_q : eq_cnt_q + EW'(1);
         else
            eq_cnt_d = '0;

         if (rep1_d == REP_MAX || rep2_d == REP_MAX) stuck_d = 1'b1;
         if (eq_cnt_d == EQ_MAX)                     corr_d  = 1'b1;

         if (win_cnt_q == WIN_END) begin
            ones_total_d  = sum;
            window_done_d = 1'b1;
            acc_d         = '0;
            win_cnt_d     = '0;
            if (dev > TOL) bias_d = 1'b1;
         end else begin
            acc_d     = sum;
            win_cnt_d = win_cnt_q + WW'(1);
         end
      end

      alarm_d = stuck_d | corr_d | bias_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         prev1_q       <= '0;
         prev2_q       <= '0;
         rep1_q        <= '0;
         rep2_q        <= '0;
         eq_cnt_q      <= '0;
         acc_q         <= '0;
         win_cnt_q     <= '0;
         ones_total_q  <= '0;
         window_done_q <= 1'b0;
         stuck_q       <= 1'b0;
         corr_q        <= 1'b0;
         bias_q        <= 1'b0;
         alarm_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev1_q       <= prev1_d;
         prev2_q       <= prev2_d;
         rep1_q        <= rep1_d;
         rep2_q        <= rep2_d;
         eq_cnt_q      <= eq_cnt_d;
         acc_q         <= acc_d;
         win_cnt_q     <= win_cnt_d;
         ones_total_q  <= ones_total_d;
         window_done_q <= window_done_d;
         stuck_q       <= stuck_d;
         corr_q        <= corr_d;
         bias_q        <= bias_d;
         alarm_q       <= alarm_d;
      end
   end

   assign bus.ones_total  = ones_total_q;
   assign bus.window_done = window_done_q;
   assign bus.stuck_alarm = stuck_q;
   assign bus.corr_alarm  = corr_q;
   assign bus.bias_alarm  = bias_q;
   assign bus.alarm       = alarm_q;
endmodule

// File: tb/tb_rng_health_monitor.sv
// Directed bench for rng_health_monitor: window sums go through a scoreboard queue,
// alarms are checked against directed expectations.
module tb_rng_health_monitor;
   localparam int unsigned WIDTH  = 32;
   localparam int unsigned WINDOW = 1024;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   rng_health_monitor_if #(.WIDTH(WIDTH), .WINDOW(WINDOW)) bus ();

   rng_health_monitor #(
      .WIDTH(WIDTH), .WINDOW(WINDOW), .REP_LIMIT(4), .BIAS_TOL(512)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;
   int m_cnt = 0;
   int m_acc = 0;
   int sb_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_alarms(input string tag, input logic s, input logic c, input logic b);
      chk({tag, ".stuck"}, 32'(bus.stuck_alarm), 32'(s));
      chk({tag, ".corr"},  32'(bus.corr_alarm),  32'(c));
      chk({tag, ".bias"},  32'(bus.bias_alarm),  32'(b));
      chk({tag, ".alarm"}, 32'(bus.alarm),       32'(s | c | b));
   endtask

   // One clock: drive at negedge, check after the edge, return at next negedge.
   task automatic smp(input logic e, input logic c, input logic [31:0] r1, input logic [31:0] r2);
      logic exp_wd;
      exp_wd    = 1'b0;
      bus.en    = e;
      bus.clear = c;
      bus.rnd1  = r1;
      bus.rnd2  = r2;
      if (c) begin
         m_cnt = 0;
         m_acc = 0;
      end else if (e) begin
         m_acc += $countones(r1);
         m_cnt++;
         if (m_cnt == int'(WINDOW)) begin
            sb_q.push_back(m_acc);
            exp_wd = 1'b1;
            m_cnt  = 0;
            m_acc  = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("window_done", 32'(bus.window_done), 32'(exp_wd));
      if (bus.window_done === 1'b1) begin
         if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
         else                  chk("ones_total", 32'(bus.ones_total), 32'(sb_q.pop_front()));
      end
      @(negedge clk);
      bus.en    = 1'b0;
      bus.clear = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) smp(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset     = 1'b1;
      bus.en    = 1'b0;
      bus.clear = 1'b0;
      bus.rnd1  = '0;
      bus.rnd2  = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("rst.ones_total", 32'(bus.ones_total), 32'd0);
      chk("rst.window_done", 32'(bus.window_done), 32'd0);
      chk_alarms("rst", 1'b0, 1'b0, 1'b0);

      // Balanced window: 16 ones per sample.
      for (int i = 0; i < int'(WINDOW); i++) begin
         logic [31:0] v;
         v = i[0] ? 32'hFFFF0000 : 32'h0000FFFF;
         smp(1'b1, 1'b0, v, ~v);
      end
      chk("bal.ones_total", 32'(bus.ones_total), 32'd16384);
      chk_alarms("bal", 1'b0, 1'b0, 1'b0);

      // Three repeats then a change: no alarm.
      for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 32'hA5A5A5A5, 32'h1000 + 32'(i));
      chk_alarms("rep3", 1'b0, 1'b0, 1'b0);
      smp(1'b1, 1'b0, 32'h5A5A5A5A, 32'h1010);
      chk_alarms("rep3chg", 1'b0, 1'b0, 1'b0);

      // Four identical samples trip stuck_alarm, which stays through idle cycles.
      for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 32'hA5A5A5A5, 32'h2000 + 32'(i));
      chk_alarms("rep4.pre", 1'b0, 1'b0, 1'b0);
      smp(1'b1, 1'b0, 32'hA5A5A5A5, 32'h2003);
      chk_alarms("rep4", 1'b1, 1'b0, 1'b0);
      idle(3);
      chk_alarms("rep4.hold", 1'b1, 1'b0, 1'b0);

      // Asynchronous reset mid-run clears everything without a clock edge.
      reset = 1'b1;
      #2;
      chk("arst.ones_total", 32'(bus.ones_total), 32'd0);
      chk("arst.window_done", 32'(bus.window_done), 32'd0);
      chk_alarms("arst", 1'b0, 1'b0, 1'b0);
      m_cnt = 0;
      m_acc = 0;
      sb_q.delete();
      @(negedge clk);
      reset = 1'b0;

      // After reset the first sample is only a reference.
      for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 32'h12345678, 32'h3000 + 32'(i));
      chk_alarms("postrst3", 1'b0, 1'b0, 1'b0);
      smp(1'b1, 1'b0, 32'h12345678, 32'h3003);
      chk_alarms("postrst4", 1'b1, 1'b0, 1'b0);
      smp(1'b0, 1'b1, 32'h0, 32'h0);
      chk_alarms("clr", 1'b0, 1'b0, 1'b0);

      // Gaps do not break a repetition run.
      smp(1'b1, 1'b0, 32'hCAFEF00D, 32'h4000);
      smp(1'b1, 1'b0, 32'hCAFEF00D, 32'h4001);
      idle(2);
      smp(1'b1, 1'b0, 32'hCAFEF00D, 32'h4002);
      chk_alarms("gap3", 1'b0, 1'b0, 1'b0);
      smp(1'b1, 1'b0, 32'hCAFEF00D, 32'h4003);
      chk_alarms("gap4", 1'b1, 1'b0, 1'b0);
      smp(1'b0, 1'b1, 32'h0, 32'h0);

      // Correlated streams.
      for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 32'h100 * 32'(i + 1) + 32'h7, 32'h100 * 32'(i + 1) + 32'h7);
      chk_alarms("eq3", 1'b0, 1'b0, 1'b0);
      smp(1'b1, 1'b0, 32'h0000_0507, 32'h0000_0507);
      chk_alarms("eq4", 1'b0, 1'b1, 1'b0);
      smp(1'b0, 1'b1, 32'h0, 32'h0);
      chk_alarms("eq.clr", 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) smp(1'b1, 1'b0, 32'h900 + 32'(i), 32'h900 + 32'(i));
      smp(1'b1, 1'b0, 32'h0000_0A00, 32'hFFFF_F5FF);
      smp(1'b1, 1'b0, 32'h0000_0B00, 32'h0000_0B00);
      chk_alarms("eq3brk", 1'b0, 1'b0, 1'b0);
      smp(1'b0, 1'b1, 32'h0, 32'h0);

      // Heavily biased window: 512*(32+31) = 32256 ones.
      for (int i = 0; i < int'(WINDOW); i++)
         smp(1'b1, 1'b0, i[0] ? 32'hFFFFFFFE : 32'hFFFFFFFF, 32'(i));
      chk("bias.ones_total", 32'(bus.ones_total), 32'd32256);
      chk_alarms("bias", 1'b0, 1'b0, 1'b1);
      smp(1'b0, 1'b1, 32'h0, 32'h0);

      // Exactly at tolerance: 512*(16+17) = 16896 passes.
      for (int i = 0; i < int'(WINDOW); i++)
         smp(1'b1, 1'b0, i[0] ? 32'h0001FFFF : 32'hFFFF0000, 32'(i));
      chk("edge.ones_total", 32'(bus.ones_total), 32'd16896);
      chk_alarms("edge", 1'b0, 1'b0, 1'b0);

      // Partial window, gap, clear+en (sample discarded), then a full window.
      for (int i = 0; i < 500; i++) smp(1'b1, 1'b0, $urandom, $urandom);
      idle(10);
      smp(1'b1, 1'b1, 32'hFFFFFFFF, 32'h0);
      chk("clren.ones_total", 32'(bus.ones_total), 32'd0);
      for (int i = 0; i < int'(WINDOW) - 1; i++) smp(1'b1, 1'b0, $urandom, $urandom);
      chk("win1023.ones_total", 32'(bus.ones_total), 32'd0);
      smp(1'b1, 1'b0, $urandom, $urandom);
      chk("sb_drained", 32'(sb_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
